// File: rtl/nroot_mul_unit_if.sv
// Operation handshake and result bus for nroot_mul_unit.
// Valid/ready: a request transfers in the cycle where start_i=1 and rdy_o=1; while rdy_o=0 start_i is ignored.
interface nroot_mul_unit_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               mode_i;
  logic [WIDTH-1:0]   x_bi;
  logic [WIDTH-1:0]   y_bi;
  logic               rdy_o;
  logic [WIDTH-1:0]   root_bo;
  logic [2*WIDTH-1:0] y_bo;
  logic [WIDTH-1:0]   rem_bo;

  modport master (
    output start_i, mode_i, x_bi, y_bi,
    input  rdy_o, root_bo, y_bo, rem_bo
  );

  modport slave (
    input  start_i, mode_i, x_bi, y_bi,
    output rdy_o, root_bo, y_bo, rem_bo
  );
endinterface

// File: rtl/nroot_mul_unit.sv
// Iterative square/cube root with post-multiply r*y, built on one shared shift-add multiplier.
// Optional macro NROOT_REM_EN: when defined, rem_bo carries x - r^n; otherwise rem_bo is 0.
module nroot_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  nroot_mul_unit_if.slave     bus,
  output logic [3:0]          dbg_state_o
);
  localparam int DW = 2 * WIDTH;
  localparam int SW = $clog2(WIDTH) + 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [SW-1:0] S_SQRT = SW'(2 * ((WIDTH - 1) / 2));
  localparam logic [SW-1:0] S_CBRT = SW'(3 * ((WIDTH - 1) / 3));

  typedef enum logic [3:0] {
    IDLE, INIT, SHIFT, MUL_A_START, MUL_A_WAIT, MUL_B_START, MUL_B_WAIT,
    CALC_B, CMP_UPD, FMUL_START, FMUL_WAIT, DONE
  } state_t;

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] yop_q, yop_d;
  logic [SW-1:0]    s_q, s_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [DW-1:0]    p_q, p_d;
  logic [DW-1:0]    b_q, b_d;
  logic             rdy_q, rdy_d;
  logic [WIDTH-1:0] root_q, root_d;
  logic [DW-1:0]    yout_q, yout_d;

  logic             mul_start;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic             mul_busy_q, mul_busy_d;
  logic [CW-1:0]    mul_cnt_q, mul_cnt_d;
  logic [DW-1:0]    mul_mcand_q, mul_mcand_d;
  logic [WIDTH-1:0] mul_mplier_q, mul_mplier_d;
  logic [DW-1:0]    mul_prod_q, mul_prod_d;

  // Root FSM; the only consumer of the multiplier.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    rx_d      = rx_q;
    acc_d     = acc_q;
    yop_d     = yop_q;
    s_d       = s_q;
    t_d       = t_q;
    p_d       = p_q;
    b_d       = b_q;
    rdy_d     = rdy_q;
    root_d    = root_q;
    yout_d    = yout_q;
    mul_start = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state_q)
      IDLE: begin
        if (rdy_q && bus.start_i) begin
          mode_d  = bus.mode_i;
          rx_d    = bus.x_bi;
          yop_d   = bus.y_bi;
          rdy_d   = 1'b0;
          state_d = INIT;
        end
      end
      INIT: begin
        acc_d   = '0;
        s_d     = mode_q ? S_CBRT : S_SQRT;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d   = acc_q << 1;
        state_d = mode_q ? MUL_A_START : CALC_B;
      end
      MUL_A_START: begin
        mul_start = 1'b1;
        mul_a     = acc_q;
        mul_b     = WIDTH'(3);
        state_d   = MUL_A_WAIT;
      end
      MUL_A_WAIT: begin
        if (!mul_busy_q) begin
          t_d     = mul_prod_q[WIDTH-1:0];
          state_d = MUL_B_START;
        end
      end
      MUL_B_START: begin
        mul_start = 1'b1;
        mul_a     = t_q;
        mul_b     = acc_q + WIDTH'(1);
        state_d   = MUL_B_WAIT;
      end
      MUL_B_WAIT: begin
        if (!mul_busy_q) begin
          p_d     = mul_prod_q;
          state_d = CALC_B;
        end
      end
      CALC_B: begin
        // Evaluated at double width so the largest shift cannot overflow.
        if (mode_q) b_d = (p_q + DW'(1)) << s_q;
        else        b_d = (({{WIDTH{1'b0}}, acc_q} << 1) + DW'(1)) << s_q;
        state_d = CMP_UPD;
      end
      CMP_UPD: begin
        if ({{WIDTH{1'b0}}, rx_q} >= b_q) begin
          rx_d  = rx_q - b_q[WIDTH-1:0];
          acc_d = acc_q + WIDTH'(1);
        end
        if (s_q == '0) begin
          state_d = FMUL_START;
        end else begin
          s_d     = mode_q ? (s_q - SW'(3)) : (s_q - SW'(2));
          state_d = SHIFT;
        end
      end
      FMUL_START: begin
        mul_start = 1'b1;
        mul_a     = acc_q;
        mul_b     = yop_q;
        state_d   = FMUL_WAIT;
      end
      FMUL_WAIT: begin
        if (!mul_busy_q) state_d = DONE;
      end
      DONE: begin
        root_d  = acc_q;
        yout_d  = mul_prod_q;
        rdy_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-add multiplier: busy for exactly WIDTH cycles after the start pulse.
  always_comb begin
    mul_busy_d   = mul_busy_q;
    mul_cnt_d    = mul_cnt_q;
    mul_mcand_d  = mul_mcand_q;
    mul_mplier_d = mul_mplier_q;
    mul_prod_d   = mul_prod_q;
    if (mul_start) begin
      mul_mcand_d  = {{WIDTH{1'b0}}, mul_a};
      mul_mplier_d = mul_b;
      mul_prod_d   = '0;
      mul_cnt_d    = CW'(WIDTH);
      mul_busy_d   = 1'b1;
    end else if (mul_busy_q) begin
      if (mul_mplier_q[0]) mul_prod_d = mul_prod_q + mul_mcand_q;
      mul_mcand_d  = mul_mcand_q << 1;
      mul_mplier_d = mul_mplier_q >> 1;
      mul_cnt_d    = mul_cnt_q - CW'(1);
      if (mul_cnt_q == CW'(1)) mul_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      mode_q       <= 1'b0;
      rx_q         <= '0;
      acc_q        <= '0;
      yop_q        <= '0;
      s_q          <= '0;
      t_q          <= '0;
      p_q          <= '0;
      b_q          <= '0;
      rdy_q        <= 1'b1;
      root_q       <= '0;
      yout_q       <= '0;
      mul_busy_q   <= 1'b0;
      mul_cnt_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_prod_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      rx_q         <= rx_d;
      acc_q        <= acc_d;
      yop_q        <= yop_d;
      s_q          <= s_d;
      t_q          <= t_d;
      p_q          <= p_d;
      b_q          <= b_d;
      rdy_q        <= rdy_d;
      root_q       <= root_d;
      yout_q       <= yout_d;
      mul_busy_q   <= mul_busy_d;
      mul_cnt_q    <= mul_cnt_d;
      mul_mcand_q  <= mul_mcand_d;
      mul_mplier_q <= mul_mplier_d;
      mul_prod_q   <= mul_prod_d;
    end
  end

`ifdef NROOT_REM_EN
  logic [WIDTH-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (state_q == DONE) rem_d = rx_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rem_q <= '0;
    else       rem_q <= rem_d;
  end

  assign bus.rem_bo = rem_q;
`else
  assign bus.rem_bo = '0;
`endif

  assign bus.rdy_o   = rdy_q;
  assign bus.root_bo = root_q;
  assign bus.y_bo    = yout_q;
  assign dbg_state_o = state_q;
endmodule
